// File: rtl/vend_ctrl_pkg.sv
// Shared types and constants for the vending transaction controller:
// FSM states, coin codes and the item price table.
package vend_pkg;

   localparam int unsigned ITEM_W = 3;

   typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

   typedef enum logic [1:0] {COIN_1, COIN_5, COIN_10, COIN_BAD} coin_t;

   function automatic logic [3:0] coin_value(input coin_t t);
      case (t)
         COIN_1:  return 4'd1;
         COIN_5:  return 4'd5;
         COIN_10: return 4'd10;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic [5:0] item_price(input logic [ITEM_W-1:0] i);
      case (i)
         3'd0:    return 6'd15;
         3'd1:    return 6'd20;
         3'd2:    return 6'd25;
         3'd3:    return 6'd30;
         3'd4:    return 6'd35;
         3'd5:    return 6'd50;
         default: return 6'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_ctrl_if.sv
// Controller-side bundle: decoder select, coin events, actuator handshakes
// and status. The controller is the slave; the machine side is the master.
interface vend_ctrl_if
   import vend_pkg::*;
#(
   parameter int unsigned CREDIT_W = 8
);
   logic [5:0]          s;
   logic                coin_valid;
   logic [1:0]          coin_type;
   logic                cancel;
   logic                dispense_ack;
   logic                change_ack;
   logic [CREDIT_W-1:0] credit;
   logic                dispense_valid;
   logic [ITEM_W-1:0]   dispense_item;
   logic                change_valid;
   logic [CREDIT_W-1:0] change_amt;
   logic                coin_reject;
   logic                short_funds;
   logic                sel_err;
   logic                busy;

   modport master (
      output s, coin_valid, coin_type, cancel, dispense_ack, change_ack,
      input  credit, dispense_valid, dispense_item, change_valid, change_amt,
             coin_reject, short_funds, sel_err, busy
   );

   modport slave (
      input  s, coin_valid, coin_type, cancel, dispense_ack, change_ack,
      output credit, dispense_valid, dispense_item, change_valid, change_amt,
             coin_reject, short_funds, sel_err, busy
   );
endinterface

// File: rtl/vend_ctrl_onehot_idx.sv
// Classifies the 6-bit item select as zero / one-hot and encodes the index.
module onehot_idx
   import vend_pkg::*;
(
   input  logic [5:0]        s,
   output logic              is_onehot,
   output logic              is_zero,
   output logic [ITEM_W-1:0] idx
);
   always_comb begin
      is_zero   = (s == '0);
      is_onehot = !is_zero && ((s & (s - 6'd1)) == '0);
      idx       = '0;
      for (int unsigned i = 0; i < 6; i++) begin
         if (s[i]) idx = ITEM_W'(i);
      end
   end
endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: credit accumulation, purchase authorisation,
// dispense/change handshakes and idle-timeout refund. All outputs registered.
module vend_ctrl
   import vend_pkg::*;
#(
   parameter int unsigned CREDIT_W    = 8,
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input logic       clk,
   input logic       rst,
   vend_ctrl_if.slave bus
);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   state_t              state, nxt_state;
   logic [CREDIT_W-1:0] credit_q, nxt_credit;
   logic [CREDIT_W-1:0] amt_q, nxt_amt;
   logic [ITEM_W-1:0]   item_q, nxt_item;
   logic [TW-1:0]       tmo_q, nxt_tmo;
   logic                disp_v_q, chg_v_q, busy_q;
   logic                rej_q, short_q, selerr_q;
   logic                nxt_rej, nxt_short, nxt_selerr;

   logic                sel_onehot, sel_zero;
   logic [ITEM_W-1:0]   sel_idx;
   logic [CREDIT_W-1:0] coin_val, price;
   logic [CREDIT_W:0]   sum;
   logic                coin_ok;

   onehot_idx u_sel (
      .s         (bus.s),
      .is_onehot (sel_onehot),
      .is_zero   (sel_zero),
      .idx       (sel_idx)
   );

   always_comb begin
      coin_val = CREDIT_W'(coin_value(coin_t'(bus.coin_type)));
      coin_ok  = bus.coin_valid && (coin_t'(bus.coin_type) != COIN_BAD);
      sum      = {1'b0, credit_q} + {1'b0, coin_val};
      price    = CREDIT_W'(item_price(sel_idx));
   end

   always_comb begin
      nxt_state  = state;
      nxt_credit = credit_q;
      nxt_amt    = amt_q;
      nxt_item   = item_q;
      nxt_tmo    = '0;
      nxt_rej    = 1'b0;
      nxt_short  = 1'b0;
      nxt_selerr = 1'b0;
      case (state)
         IDLE: begin
            if (coin_ok) begin
               nxt_credit = coin_val;
               nxt_state  = CREDIT;
            end else if (bus.coin_valid) begin
               nxt_rej = 1'b1;
            end
         end
         CREDIT: begin
            if (bus.cancel) begin
               nxt_state = CHANGE;
               nxt_amt   = credit_q;
               nxt_rej   = bus.coin_valid;
            end else if (sel_onehot && credit_q >= price) begin
               nxt_credit = credit_q - price;
               nxt_item   = sel_idx;
               nxt_state  = DISPENSE;
               nxt_rej    = bus.coin_valid;
            end else begin
               // A failed select does not block a coin arriving in the same cycle.
               nxt_short  = sel_onehot;
               nxt_selerr = !sel_zero && !sel_onehot;
               if (coin_ok && !sum[CREDIT_W]) nxt_credit = sum[CREDIT_W-1:0];
               else if (bus.coin_valid)       nxt_rej    = 1'b1;
               if (!bus.coin_valid && sel_zero) begin
                  if (tmo_q == TMO_LAST) begin
                     nxt_state = CHANGE;
                     nxt_amt   = credit_q;
                  end else begin
                     nxt_tmo = tmo_q + 1'b1;
                  end
               end
            end
         end
         DISPENSE: begin
            nxt_rej = bus.coin_valid;
            if (bus.dispense_ack) begin
               if (credit_q != '0) begin
                  nxt_state = CHANGE;
                  nxt_amt   = credit_q;
               end else begin
                  nxt_state = IDLE;
               end
            end
         end
         CHANGE: begin
            nxt_rej = bus.coin_valid;
            if (bus.change_ack) begin
               nxt_credit = '0;
               nxt_amt    = '0;
               nxt_state  = IDLE;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         credit_q <= '0;
         amt_q    <= '0;
         item_q   <= '0;
         tmo_q    <= '0;
         disp_v_q <= 1'b0;
         chg_v_q  <= 1'b0;
         busy_q   <= 1'b0;
         rej_q    <= 1'b0;
         short_q  <= 1'b0;
         selerr_q <= 1'b0;
      end else begin
         state    <= nxt_state;
         credit_q <= nxt_credit;
         amt_q    <= nxt_amt;
         item_q   <= nxt_item;
         tmo_q    <= nxt_tmo;
         disp_v_q <= (nxt_state == DISPENSE);
         chg_v_q  <= (nxt_state == CHANGE);
         busy_q   <= (nxt_state == DISPENSE) || (nxt_state == CHANGE);
         rej_q    <= nxt_rej;
         short_q  <= nxt_short;
         selerr_q <= nxt_selerr;
      end
   end

   assign bus.credit         = credit_q;
   assign bus.dispense_valid = disp_v_q;
   assign bus.dispense_item  = item_q;
   assign bus.change_valid   = chg_v_q;
   assign bus.change_amt     = amt_q;
   assign bus.coin_reject    = rej_q;
   assign bus.short_funds    = short_q;
   assign bus.sel_err        = selerr_q;
   assign bus.busy           = busy_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: scenario tasks with inline checks plus a
// scoreboard of expected dispense/change requests popped as the DUT raises them.
module tb_vend_ctrl;
   import vend_pkg::*;

   localparam int unsigned CW  = 8;
   localparam int unsigned TMO = 1000;

   typedef enum {K_DISP, K_CHG} kind_t;
   typedef struct {
      kind_t      kind;
      logic [7:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   int   price_tab[6] = '{15, 20, 25, 30, 35, 50};

   always #5 clk = ~clk;

   vend_ctrl_if #(.CREDIT_W(CW)) bus ();

   vend_ctrl #(.CREDIT_W(CW), .TIMEOUT_CYC(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic dv_prev = 1'b0;
   logic cv_prev = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (bus.dispense_valid && !dv_prev) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_disp_unexpected item=%0d required=none", bus.dispense_item);
         end else begin
            e = exp_q.pop_front();
            if (e.kind != K_DISP || e.val !== 8'(bus.dispense_item)) begin
               bad++;
               $display("FAIL sb_disp got=item%0d required=kind%0d/%0d", bus.dispense_item, e.kind, e.val);
            end
         end
      end
      if (bus.change_valid && !cv_prev) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_chg_unexpected amt=%0d required=none", bus.change_amt);
         end else begin
            e = exp_q.pop_front();
            if (e.kind != K_CHG || e.val !== bus.change_amt) begin
               bad++;
               $display("FAIL sb_chg got=amt%0d required=kind%0d/%0d", bus.change_amt, e.kind, e.val);
            end
         end
      end
      dv_prev = bus.dispense_valid;
      cv_prev = bus.change_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_coin(input logic [1:0] t);
      bus.coin_valid = 1'b1;
      bus.coin_type  = t;
      tick();
      bus.coin_valid = 1'b0;
      bus.coin_type  = 2'd0;
   endtask

   task automatic test_reset();
      bus.s = '0; bus.coin_valid = 0; bus.coin_type = 0; bus.cancel = 0;
      bus.dispense_ack = 0; bus.change_ack = 0;
      #2;
      total++;
      if ({bus.credit, bus.dispense_valid, bus.change_valid, bus.change_amt,
           bus.coin_reject, bus.short_funds, bus.sel_err, bus.busy} !== '0) begin
         bad++;
         $display("FAIL reset_outputs credit=%0d dv=%b cv=%b busy=%b required=all0",
                  bus.credit, bus.dispense_valid, bus.change_valid, bus.busy);
      end
      @(posedge clk); #1; rst = 1'b0;
      tick();
      total++;
      if (bus.credit !== 8'd0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_release credit=%0d busy=%b required=0/0", bus.credit, bus.busy);
      end
   endtask

   task automatic test_exact_pay();
      put_coin(2'd2);
      put_coin(2'd1);
      total++;
      if (bus.credit !== 8'd15) begin
         bad++; $display("FAIL exact_credit got=%0d required=15", bus.credit);
      end
      exp_q.push_back('{K_DISP, 8'd0});
      bus.s = 6'b000001; tick(); bus.s = '0;
      total++;
      if (bus.dispense_valid !== 1'b1 || bus.busy !== 1'b1 || bus.credit !== 8'd0) begin
         bad++;
         $display("FAIL exact_dispense dv=%b busy=%b credit=%0d required=1/1/0",
                  bus.dispense_valid, bus.busy, bus.credit);
      end
      bus.dispense_ack = 1'b1; tick(); bus.dispense_ack = 1'b0;
      total++;
      if (bus.dispense_valid !== 1'b0 || bus.change_valid !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL exact_done dv=%b cv=%b busy=%b required=0/0/0",
                  bus.dispense_valid, bus.change_valid, bus.busy);
      end
   endtask

   task automatic test_overpay_change();
      for (int i = 0; i < 3; i++) put_coin(2'd2);
      exp_q.push_back('{K_DISP, 8'd1});
      bus.s = 6'b000010; tick(); bus.s = '0;
      total++;
      if (bus.credit !== 8'd10 || bus.dispense_item !== 3'd1) begin
         bad++;
         $display("FAIL over_dispense credit=%0d item=%0d required=10/1", bus.credit, bus.dispense_item);
      end
      exp_q.push_back('{K_CHG, 8'd10});
      bus.dispense_ack = 1'b1; tick(); bus.dispense_ack = 1'b0;
      total++;
      if (bus.change_valid !== 1'b1 || bus.change_amt !== 8'd10 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL over_change cv=%b amt=%0d busy=%b required=1/10/1",
                  bus.change_valid, bus.change_amt, bus.busy);
      end
      bus.change_ack = 1'b1; tick(); bus.change_ack = 1'b0;
      total++;
      if (bus.credit !== 8'd0 || bus.change_valid !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL over_done credit=%0d cv=%b busy=%b required=0/0/0",
                  bus.credit, bus.change_valid, bus.busy);
      end
   endtask

   task automatic test_short_cancel();
      put_coin(2'd2);
      bus.s = 6'b100000; tick(); bus.s = '0;
      total++;
      if (bus.short_funds !== 1'b1 || bus.credit !== 8'd10 || bus.dispense_valid !== 1'b0) begin
         bad++;
         $display("FAIL short_pulse sf=%b credit=%0d dv=%b required=1/10/0",
                  bus.short_funds, bus.credit, bus.dispense_valid);
      end
      tick();
      total++;
      if (bus.short_funds !== 1'b0) begin
         bad++; $display("FAIL short_width sf=%b required=0", bus.short_funds);
      end
      exp_q.push_back('{K_CHG, 8'd10});
      bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
      total++;
      if (bus.change_valid !== 1'b1 || bus.change_amt !== 8'd10) begin
         bad++;
         $display("FAIL cancel_change cv=%b amt=%0d required=1/10", bus.change_valid, bus.change_amt);
      end
      bus.change_ack = 1'b1; tick(); bus.change_ack = 1'b0;
      total++;
      if (bus.credit !== 8'd0 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL cancel_done credit=%0d busy=%b required=0/0", bus.credit, bus.busy);
      end
   endtask

   task automatic test_simultaneous();
      put_coin(2'd2);
      put_coin(2'd2);
      exp_q.push_back('{K_DISP, 8'd0});
      bus.s = 6'b000001; bus.coin_valid = 1'b1; bus.coin_type = 2'd1;
      tick();
      bus.s = '0; bus.coin_valid = 1'b0;
      total++;
      if (bus.coin_reject !== 1'b1 || bus.credit !== 8'd5 || bus.dispense_valid !== 1'b1) begin
         bad++;
         $display("FAIL simul_buy rej=%b credit=%0d dv=%b required=1/5/1",
                  bus.coin_reject, bus.credit, bus.dispense_valid);
      end
      exp_q.push_back('{K_CHG, 8'd5});
      bus.dispense_ack = 1'b1; tick(); bus.dispense_ack = 1'b0;
      bus.change_ack = 1'b1; tick(); bus.change_ack = 1'b0;
      put_coin(2'd2);
      bus.s = 6'b000011; tick(); bus.s = '0;
      total++;
      if (bus.sel_err !== 1'b1 || bus.dispense_valid !== 1'b0 || bus.credit !== 8'd10) begin
         bad++;
         $display("FAIL selerr_pulse se=%b dv=%b credit=%0d required=1/0/10",
                  bus.sel_err, bus.dispense_valid, bus.credit);
      end
      bus.s = 6'b110000; bus.coin_valid = 1'b1; bus.coin_type = 2'd1;
      tick();
      bus.s = '0; bus.coin_valid = 1'b0;
      total++;
      if (bus.sel_err !== 1'b1 || bus.coin_reject !== 1'b0 || bus.credit !== 8'd15) begin
         bad++;
         $display("FAIL selerr_coin se=%b rej=%b credit=%0d required=1/0/15",
                  bus.sel_err, bus.coin_reject, bus.credit);
      end
      exp_q.push_back('{K_CHG, 8'd15});
      bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
      bus.change_ack = 1'b1; tick(); bus.change_ack = 1'b0;
   endtask

   task automatic test_prices();
      int target;
      int cr;
      for (int i = 0; i < 6; i++) begin
         target = price_tab[i] - 1;
         cr = 0;
         while (cr + 10 <= target) begin put_coin(2'd2); cr += 10; end
         while (cr < target) begin put_coin(2'd0); cr += 1; end
         bus.s = 6'(1 << i); tick(); bus.s = '0;
         total++;
         if (bus.short_funds !== 1'b1 || bus.credit !== 8'(target) || bus.dispense_valid !== 1'b0) begin
            bad++;
            $display("FAIL price_short item=%0d sf=%b credit=%0d required=1/%0d",
                     i, bus.short_funds, bus.credit, target);
         end
         put_coin(2'd0);
         exp_q.push_back('{K_DISP, 8'(i)});
         bus.s = 6'(1 << i); tick(); bus.s = '0;
         total++;
         if (bus.dispense_valid !== 1'b1 || bus.credit !== 8'd0) begin
            bad++;
            $display("FAIL price_exact item=%0d dv=%b credit=%0d required=1/0",
                     i, bus.dispense_valid, bus.credit);
         end
         bus.dispense_ack = 1'b1; tick(); bus.dispense_ack = 1'b0;
      end
   endtask

   task automatic test_overflow_busy();
      for (int i = 0; i < 25; i++) put_coin(2'd2);
      put_coin(2'd2);
      total++;
      if (bus.coin_reject !== 1'b1 || bus.credit !== 8'd250) begin
         bad++;
         $display("FAIL ovf_reject rej=%b credit=%0d required=1/250", bus.coin_reject, bus.credit);
      end
      put_coin(2'd1);
      total++;
      if (bus.coin_reject !== 1'b0 || bus.credit !== 8'd255) begin
         bad++;
         $display("FAIL ovf_fill rej=%b credit=%0d required=0/255", bus.coin_reject, bus.credit);
      end
      put_coin(2'd0);
      total++;
      if (bus.coin_reject !== 1'b1 || bus.credit !== 8'd255) begin
         bad++;
         $display("FAIL ovf_edge rej=%b credit=%0d required=1/255", bus.coin_reject, bus.credit);
      end
      exp_q.push_back('{K_DISP, 8'd5});
      bus.s = 6'b100000; tick(); bus.s = '0;
      put_coin(2'd2);
      total++;
      if (bus.coin_reject !== 1'b1 || bus.credit !== 8'd205 || bus.dispense_valid !== 1'b1) begin
         bad++;
         $display("FAIL disp_coin rej=%b credit=%0d dv=%b required=1/205/1",
                  bus.coin_reject, bus.credit, bus.dispense_valid);
      end
      bus.cancel = 1'b1; bus.s = 6'b000001; tick(); bus.cancel = 1'b0; bus.s = '0;
      total++;
      if (bus.dispense_valid !== 1'b1 || bus.change_valid !== 1'b0 || bus.credit !== 8'd205) begin
         bad++;
         $display("FAIL disp_ignore dv=%b cv=%b credit=%0d required=1/0/205",
                  bus.dispense_valid, bus.change_valid, bus.credit);
      end
      exp_q.push_back('{K_CHG, 8'd205});
      bus.dispense_ack = 1'b1; tick(); bus.dispense_ack = 1'b0;
      put_coin(2'd3);
      total++;
      if (bus.coin_reject !== 1'b1 || bus.change_valid !== 1'b1 || bus.change_amt !== 8'd205) begin
         bad++;
         $display("FAIL chg_coin rej=%b cv=%b amt=%0d required=1/1/205",
                  bus.coin_reject, bus.change_valid, bus.change_amt);
      end
      bus.change_ack = 1'b1; tick(); bus.change_ack = 1'b0;
      total++;
      if (bus.credit !== 8'd0 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL ovf_done credit=%0d busy=%b required=0/0", bus.credit, bus.busy);
      end
   endtask

   task automatic test_timeout();
      int n;
      put_coin(2'd1);
      for (int i = 0; i < 600; i++) tick();
      put_coin(2'd0);
      for (int i = 0; i < 600; i++) tick();
      total++;
      if (bus.change_valid !== 1'b0 || bus.credit !== 8'd6) begin
         bad++;
         $display("FAIL tmo_restart cv=%b credit=%0d required=0/6", bus.change_valid, bus.credit);
      end
      for (int i = 0; i < 20; i++) tick();
      bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
      exp_q.push_back('{K_CHG, 8'd6});
      bus.change_ack = 1'b1; tick(); bus.change_ack = 1'b0;
      exp_q.push_back('{K_CHG, 8'd5});
      put_coin(2'd1);
      n = 0;
      while (bus.change_valid !== 1'b1 && n < 2 * TMO) begin tick(); n++; end
      total++;
      if (n != TMO || bus.change_amt !== 8'd5) begin
         bad++;
         $display("FAIL tmo_refund cycles=%0d amt=%0d required=%0d/5", n, bus.change_amt, TMO);
      end
      bus.change_ack = 1'b1; tick(); bus.change_ack = 1'b0;
      total++;
      if (bus.credit !== 8'd0 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL tmo_done credit=%0d busy=%b required=0/0", bus.credit, bus.busy);
      end
   endtask

   task automatic test_reset_mid();
      put_coin(2'd2);
      put_coin(2'd2);
      exp_q.push_back('{K_DISP, 8'd1});
      bus.s = 6'b000010; tick(); bus.s = '0;
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      total++;
      if ({bus.credit, bus.dispense_valid, bus.change_valid, bus.busy, bus.coin_reject} !== '0) begin
         bad++;
         $display("FAIL rst_mid credit=%0d dv=%b cv=%b busy=%b required=all0",
                  bus.credit, bus.dispense_valid, bus.change_valid, bus.busy);
      end
      @(posedge clk); #1; rst = 1'b0;
      bus.dispense_ack = 1'b1; bus.change_ack = 1'b1;
      tick();
      bus.dispense_ack = 1'b0; bus.change_ack = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      total++;
      if (bus.credit !== 8'd0 || bus.change_valid !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_norefund credit=%0d cv=%b busy=%b required=0/0/0",
                  bus.credit, bus.change_valid, bus.busy);
      end
   endtask

   initial begin
      test_reset();
      test_exact_pay();
      test_overpay_change();
      test_short_cancel();
      test_simultaneous();
      test_prices();
      test_overflow_busy();
      test_timeout();
      test_reset_mid();
      tick();
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL sb_leftover pending=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Transaction controller directly downstream of the item-select decoder: consumes the six one-hot select lines s0..s5 plus coin events.
- Accumulates credit, authorises a purchase when credit covers the item price, and hands off to the dispenser and change-return mechanisms via ready/ack handshakes.
- One instance per machine, between the decoder and the actuator drivers.

Parameters:
- CREDIT_W, 8, width of credit and change values (max credit 2^CREDIT_W-1).
- TIMEOUT_CYC, 1000, idle cycles in CREDIT before automatic refund; counter width $clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s  in  6  item select from decoder (s[0]=s0 .. s[5]=s5), sampled every cycle.
- coin_valid  in  1  one-cycle coin strobe.
- coin_type  in  2  0=1 unit, 1=5 units, 2=10 units, 3=invalid coin.
- cancel  in  1  one-cycle refund request.
- dispense_ack  in  1  dispenser done.
- change_ack  in  1  change paid.
- credit  out  CREDIT_W  current credit.
- dispense_valid  out  1  dispense request, held until ack.
- dispense_item  out  3  item index 0..5, stable while dispense_valid.
- change_valid  out  1  change request, held until ack.
- change_amt  out  CREDIT_W  amount to return, stable while change_valid.
- coin_reject  out  1  one-cycle pulse: coin returned, not credited.
- short_funds  out  1  one-cycle pulse: valid select with credit < price.
- sel_err  out  1  one-cycle pulse: s non-zero and not one-hot.
- busy  out  1  high in DISPENSE or CHANGE.

Behaviour:
- Reset (async, rst=1): state=IDLE; credit=0; all outputs 0; timeout counter=0. Reset mid-transaction drops any pending dispense/change; no refund.
- All outputs are registered; the response appears the cycle after the sampled input.
- IDLE: valid coin → credit=value, go CREDIT. coin_type=3 → coin_reject pulse. s is ignored; all prices are nonzero.
- CREDIT:
  - Priority: cancel > select > coin.
  - cancel → go CHANGE with change_amt=credit. A coin in the same cycle is rejected.
  - s one-hot (index i) and credit ≥ PRICE[i] → credit -= PRICE[i], dispense_item=i, go DISPENSE. A coin in the same cycle is rejected.
  - s one-hot and credit < PRICE[i] → short_funds pulse, stay in CREDIT. A coin in the same cycle is accepted.
  - s nonzero and not one-hot → sel_err pulse, no purchase. A coin in the same cycle is accepted.
  - Valid coin with credit+value > 2^CREDIT_W-1 → coin_reject pulse, credit unchanged (no wrap, no saturation).
  - Timeout counter clears on any coin, select or cancel event. When it reaches TIMEOUT_CYC → go CHANGE with full credit.
- DISPENSE: dispense_valid=1. On dispense_ack → dispense_valid=0, then go CHANGE if credit>0, else IDLE. Any coin → coin_reject. s and cancel are ignored.
- CHANGE: change_valid=1, change_amt=credit. On change_ack → credit=0, change_valid=0, go IDLE. Any coin → coin_reject. s and cancel are ignored.
- An ack outside its state is ignored. An ack in the entry cycle is honoured; minimum handshake is 1 cycle.
- busy=1 exactly when state is DISPENSE or CHANGE.

Decomposition:
- Package vend_pkg:
  - state enum {IDLE, CREDIT, DISPENSE, CHANGE}.
  - coin type codes and COIN_VALUE function (1/5/10/0).
  - PRICE table, items 0..5: 15, 20, 25, 30, 35, 50.
  - ITEM_W=3.
- One natural sub-module, onehot_idx: 6-bit one-hot check plus index encode (outputs is_onehot, is_zero, idx[2:0]). Keep the timeout counter inline.

Test Plan:
- Exact pay: 10+5 coins, then s=6'b000001 → credit 15; dispense_valid, dispense_item=0; ack → IDLE, credit=0, no change_valid.
- Overpay with change: coins 10,10,10, then s[3] (price 30)... use s[1] (price 20) → dispense item 1; ack → change_valid, change_amt=10; change_ack → credit=0.
- Short funds then cancel: coin 10, s[5] → short_funds pulse, credit stays 10; cancel → change_amt=10.
- Simultaneous events: in CREDIT with 20, s[0] plus coin 5 in the same cycle → purchase, coin_reject, credit 5. s=6'b000011 → sel_err, no dispense.
- Overflow/busy: credit 250 + coin 10 → coin_reject, credit 250. Coin during DISPENSE → coin_reject, credit unchanged.
- Timeout and reset: coin 5 then idle TIMEOUT_CYC cycles → CHANGE with amt 5. Assert rst during DISPENSE → all outputs 0 immediately, state IDLE.
